// File: rtl/servo_pkg.sv
// servo_pkg: shared servo timing constants, duty type and clamp helper
package servo_pkg;
    localparam int SERVO_PRESCALE    = 488;
    localparam int SERVO_SLOTS       = 1024;
    localparam int SERVO_DUTY_MIN    = 51;
    localparam int SERVO_DUTY_MAX    = 92;
    localparam int SERVO_DUTY_CENTER = 77;
    localparam int SERVO_DUTY_W      = 10;

    typedef logic [SERVO_DUTY_W-1:0] duty_t;

    function automatic duty_t clamp_duty(input duty_t d, input duty_t lo, input duty_t hi);
        return (d < lo) ? lo : ((d > hi) ? hi : d);
    endfunction
endpackage

// File: rtl/servo_frame_timer.sv
// servo_frame_timer: prescaler plus 10-bit slot counter marking slot ticks and frame boundaries
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int PRESCALE = SERVO_PRESCALE
) (
    input  logic  clk25mhz,
    input  logic  reset,
    output duty_t slot,
    output logic  slot_tick,
    output logic  frame_boundary
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] r_pre;
    duty_t         r_slot;

    assign slot           = r_slot;
    assign slot_tick      = (r_pre == PW'(PRESCALE - 1));
    assign frame_boundary = slot_tick && (r_slot == '1);

    always_ff @(posedge clk25mhz or posedge reset) begin
        if (reset) begin
            r_pre  <= '0;
            r_slot <= '0;
        end else begin
            r_pre <= slot_tick ? '0 : r_pre + 1'b1;
            if (slot_tick) r_slot <= r_slot + 1'b1;
        end
    end
endmodule

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: frame-based servo PWM with clamped, slew-limited duty applied only at frame boundaries
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int PRESCALE   = SERVO_PRESCALE,
    parameter int DUTY_MIN   = SERVO_DUTY_MIN,
    parameter int DUTY_MAX   = SERVO_DUTY_MAX,
    parameter int DUTY_RESET = SERVO_DUTY_CENTER,
    parameter int SLEW_STEP  = 0
) (
    input  logic                    clk25mhz,
    input  logic                    reset,
    input  logic [SERVO_DUTY_W-1:0] duty_cycle_input,
    input  logic                    enable,
    output logic                    servoSignal,
    output logic                    frame_start,
    output logic [SERVO_DUTY_W-1:0] duty_active,
    output logic                    clamped
);
    localparam duty_t LO   = duty_t'(DUTY_MIN);
    localparam duty_t HI   = duty_t'(DUTY_MAX);
    localparam duty_t STEP = duty_t'(SLEW_STEP);

    duty_t              w_slot, w_next_slot, w_target, w_slewed, w_next_duty;
    logic               w_slot_tick, w_boundary, w_next_en;
    logic signed [10:0] w_diff, w_mag;

    duty_t r_duty;
    logic  r_en, r_clamped, r_out, r_fs;

    servo_frame_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk25mhz       (clk25mhz),
        .reset          (reset),
        .slot           (w_slot),
        .slot_tick      (w_slot_tick),
        .frame_boundary (w_boundary)
    );

    assign w_target = clamp_duty(duty_cycle_input, LO, HI);
    assign w_diff   = $signed({1'b0, w_target}) - $signed({1'b0, r_duty});
    assign w_mag    = (w_diff < 0) ? -w_diff : w_diff;
    assign w_slewed = (SLEW_STEP == 0 || w_mag <= $signed({1'b0, STEP})) ? w_target :
                      (w_diff < 0) ? r_duty - STEP : r_duty + STEP;

    // The output register looks one cycle ahead so the pulse rises together with frame_start.
    assign w_next_slot = w_slot_tick ? w_slot + 1'b1 : w_slot;
    assign w_next_duty = w_boundary ? w_slewed : r_duty;
    assign w_next_en   = w_boundary ? enable : r_en;

    always_ff @(posedge clk25mhz or posedge reset) begin
        if (reset) begin
            r_duty    <= duty_t'(DUTY_RESET);
            r_en      <= 1'b0;
            r_clamped <= 1'b0;
            r_out     <= 1'b0;
            r_fs      <= 1'b0;
        end else begin
            r_fs  <= w_boundary;
            r_out <= w_next_en && (w_next_slot < w_next_duty);
            if (w_boundary) begin
                r_duty    <= w_slewed;
                r_en      <= enable;
                r_clamped <= (duty_cycle_input < LO) || (duty_cycle_input > HI);
            end
        end
    end

    assign servoSignal = r_out;
    assign frame_start = r_fs;
    assign duty_active = r_duty;
    assign clamped     = r_clamped;
endmodule
